// File: rtl/cali_pkg.sv
// Shared types and default widths for the calibration error front-end.
package cali_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int ERR_W_DEF   = 16;
  localparam int RL_W_DEF    = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_HOLD   = 2'd3
  } cali_state_e;

endpackage

// File: rtl/bbpd_runlen_det.sv
// Tracks the previous bang-bang PD decision and the length of the current run of equal decisions.
module bbpd_runlen_det
  import cali_pkg::*;
#(
  parameter int RL_W = RL_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bbpd,
  input  logic            active,
  output logic            toggle,
  output logic [RL_W-1:0] rl_nxt
);

  logic            last_bbpd;
  logic [RL_W-1:0] rl;

  function automatic logic [RL_W-1:0] sat_inc(input logic [RL_W-1:0] v);
    return (&v) ? v : v + RL_W'(1);
  endfunction

  assign toggle = bbpd ^ last_bbpd;

  // A toggle starts a new run of length one; outside RUN/HOLD the count is parked at zero.
  always_comb begin
    rl_nxt = '0;
    if (active) rl_nxt = toggle ? RL_W'(1) : sat_inc(rl);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_bbpd <= 1'b0;
      rl        <= '0;
    end else begin
      last_bbpd <= bbpd;
      rl        <= rl_nxt;
    end
  end

endmodule

// File: rtl/cali_err_frontend.sv
// Calibration front-end: fractional phase accumulator for the DTC plus the BBPD-driven
// error generator and warm-up / hold sequencing that gates the downstream RLS stage.
module cali_err_frontend
  import cali_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ERR_W   = ERR_W_DEF,
  parameter int RL_W    = RL_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [PHASE_W-1:0] FCW_FRAC,
  input  logic               BBPD,
  input  logic [2:0]         ERR_GAIN,
  input  logic [7:0]         SETTLE_CNT,
  input  logic [RL_W-1:0]    RUN_MAX,
  output logic [PHASE_W-1:0] PHASE_OUT,
  output logic               DIV_CARRY,
  output logic [ERR_W-1:0]   ERR_OUT,
  output logic               CALI_EN,
  output logic               HOLD
);

  cali_state_e st, st_nxt;
  logic [7:0]                scnt;
  logic [PHASE_W-1:0]        acc_p1;
  logic                      carry_p1;
  logic [PHASE_W:0]          sum_p0;
  logic                      toggle;
  logic [RL_W-1:0]           rl_nxt;
  logic signed [ERR_W-1:0]   err_p0;
  logic signed [ERR_W-1:0]   err_p1;

  // Gain 0 would put the step at full scale (+2^(ERR_W-1)), which is not representable.
  function automatic logic signed [ERR_W-1:0] err_step(input logic [2:0] g);
    logic [2:0] geff;
    geff = (g == 3'd0) ? 3'd1 : g;
    return ERR_W'(1) << (ERR_W - 1 - int'(geff));
  endfunction

  bbpd_runlen_det #(.RL_W(RL_W)) u_runlen (
    .clk    (CLK),
    .rst    (RST),
    .bbpd   (BBPD),
    .active ((st == ST_RUN) || (st == ST_HOLD)),
    .toggle (toggle),
    .rl_nxt (rl_nxt)
  );

  always_comb begin
    st_nxt = st;
    if (!EN) begin
      st_nxt = ST_IDLE;
    end else begin
      case (st)
        ST_IDLE:   st_nxt = ST_SETTLE;
        ST_SETTLE: if (scnt == SETTLE_CNT) st_nxt = ST_RUN;
        ST_RUN:    if ((RUN_MAX != '0) && (rl_nxt >= RUN_MAX)) st_nxt = ST_HOLD;
        ST_HOLD:   if (toggle) st_nxt = ST_RUN;
        default:   st_nxt = ST_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: accumulate phase and form the signed error for the upcoming state
  always_comb begin
    sum_p0 = {1'b0, acc_p1} + {1'b0, FCW_FRAC};
    err_p0 = '0;
    if (st_nxt == ST_RUN) err_p0 = BBPD ? err_step(ERR_GAIN) : -err_step(ERR_GAIN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st       <= ST_IDLE;
      scnt     <= '0;
      acc_p1   <= '0;
      carry_p1 <= 1'b0;
      err_p1   <= '0;
    end else begin
      st       <= st_nxt;
      scnt     <= (st == ST_SETTLE && EN) ? scnt + 8'd1 : 8'd0;
      err_p1   <= err_p0;
      if (EN) begin
        acc_p1   <= sum_p0[PHASE_W-1:0];
        carry_p1 <= sum_p0[PHASE_W];
      end else begin
        carry_p1 <= 1'b0;
      end
    end
  end

  assign PHASE_OUT = acc_p1;
  assign DIV_CARRY = carry_p1;
  assign ERR_OUT   = err_p1;
  assign CALI_EN   = (st == ST_RUN);
  assign HOLD      = (st == ST_HOLD);

endmodule

// File: tb/tb_cali_err_frontend.sv
// Directed and randomized checks of cali_err_frontend against a behavioural model.
module tb_cali_err_frontend;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [15:0] FCW_FRAC;
  logic        BBPD;
  logic [2:0]  ERR_GAIN;
  logic [7:0]  SETTLE_CNT;
  logic [5:0]  RUN_MAX;
  logic [15:0] PHASE_OUT;
  logic        DIV_CARRY;
  logic [15:0] ERR_OUT;
  logic        CALI_EN;
  logic        HOLD;

  int n_cmp = 0;
  int n_err = 0;

  localparam int M_IDLE = 0, M_SETTLE = 1, M_RUN = 2, M_HOLD = 3;
  int m_acc, m_carry, m_state, m_scnt, m_rl, m_last, m_err;

  cali_err_frontend dut (
    .CLK(CLK), .RST(RST), .EN(EN), .FCW_FRAC(FCW_FRAC), .BBPD(BBPD),
    .ERR_GAIN(ERR_GAIN), .SETTLE_CNT(SETTLE_CNT), .RUN_MAX(RUN_MAX),
    .PHASE_OUT(PHASE_OUT), .DIV_CARRY(DIV_CARRY), .ERR_OUT(ERR_OUT),
    .CALI_EN(CALI_EN), .HOLD(HOLD)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_carry = 0; m_state = M_IDLE; m_scnt = 0;
    m_rl = 0; m_last = 0; m_err = 0;
  endtask

  // Advance the model by one rising edge using the currently applied inputs.
  task automatic model_edge();
    int nxt, g, step, rl_new;
    bit tog;
    tog = (int'(BBPD) != m_last);
    if (m_state == M_RUN || m_state == M_HOLD)
      rl_new = tog ? 1 : ((m_rl + 1 > 63) ? 63 : m_rl + 1);
    else
      rl_new = 0;
    nxt = m_state;
    if (!EN) nxt = M_IDLE;
    else begin
      case (m_state)
        M_IDLE:   nxt = M_SETTLE;
        M_SETTLE: if (m_scnt == int'(SETTLE_CNT)) nxt = M_RUN;
        M_RUN:    if (RUN_MAX != 0 && rl_new >= int'(RUN_MAX)) nxt = M_HOLD;
        M_HOLD:   if (tog) nxt = M_RUN;
        default:  nxt = M_IDLE;
      endcase
    end
    g = (ERR_GAIN == 0) ? 1 : int'(ERR_GAIN);
    step = 1 << (15 - g);
    m_err = (nxt == M_RUN) ? (BBPD ? step : -step) : 0;
    m_scnt = (m_state == M_SETTLE && EN) ? (m_scnt + 1) % 256 : 0;
    if (EN) begin
      m_acc = m_acc + int'(FCW_FRAC);
      m_carry = m_acc / 65536;
      m_acc = m_acc % 65536;
    end else begin
      m_carry = 0;
    end
    m_state = nxt;
    m_rl = rl_new;
    m_last = int'(BBPD);
  endtask

  task automatic check_all(input string tag);
    logic [15:0] e16;
    e16 = m_err[15:0];
    chk({tag, ".phase"}, 32'(PHASE_OUT), 32'(m_acc));
    chk({tag, ".carry"}, 32'(DIV_CARRY), 32'(m_carry));
    chk({tag, ".err"},   32'(ERR_OUT),   32'(e16));
    chk({tag, ".cali"},  32'(CALI_EN),   32'(m_state == M_RUN));
    chk({tag, ".hold"},  32'(HOLD),      32'(m_state == M_HOLD));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  // Clock edges until CALI_EN rises; 0 if it never does within the budget.
  task automatic edges_to_cali(input string tag, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(tag);
      if (CALI_EN === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] exp_ph [4];
    logic [15:0] frozen;
    int n;
    exp_ph = '{16'h4000, 16'h8000, 16'hC000, 16'h0000};

    RST = 1'b1; EN = 1'b0; BBPD = 1'b0; FCW_FRAC = '0;
    ERR_GAIN = 3'd3; SETTLE_CNT = 8'd4; RUN_MAX = '0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Phase accumulator wrap
    EN = 1'b1; FCW_FRAC = 16'h4000; SETTLE_CNT = 8'd200;
    for (int i = 0; i < 4; i++) begin
      tick("wrap");
      chk("phase_seq", 32'(PHASE_OUT), 32'(exp_ph[i]));
      chk("carry_seq", 32'(DIV_CARRY), 32'(i == 3));
    end
    EN = 1'b0;
    tick("idle0");

    // Warm-up latency
    SETTLE_CNT = 8'd4; FCW_FRAC = 16'h1234; EN = 1'b1;
    edges_to_cali("settle4", n);
    chk("settle4_edges", 32'(n), 32'd6);
    EN = 1'b0;
    tick("idle1");
    SETTLE_CNT = 8'd0; EN = 1'b1;
    edges_to_cali("settle0", n);
    chk("settle0_edges", 32'(n), 32'd2);

    // Error magnitude vs gain
    RUN_MAX = '0; ERR_GAIN = 3'd3;
    for (int i = 0; i < 6; i++) begin
      BBPD = (i % 2 == 0);
      tick("alt_g3");
      chk("err_g3", 32'(ERR_OUT), BBPD ? 32'h1000 : 32'hF000);
    end
    ERR_GAIN = 3'd0;
    for (int i = 0; i < 4; i++) begin
      BBPD = (i % 2 == 0);
      tick("alt_g0");
      chk("err_g0", 32'(ERR_OUT), BBPD ? 32'h4000 : 32'hC000);
    end

    // Run-length hold and release
    ERR_GAIN = 3'd3; RUN_MAX = 6'd8; BBPD = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick("runlen");
      if (i == 7) chk("hold_early", 32'(HOLD), 32'd0);
    end
    chk("hold_set", 32'(HOLD), 32'd1);
    chk("hold_cali", 32'(CALI_EN), 32'd0);
    chk("hold_err", 32'(ERR_OUT), 32'd0);
    tick("hold_stay");
    tick("hold_stay");
    BBPD = 1'b0;
    tick("release");
    chk("release_hold", 32'(HOLD), 32'd0);
    chk("release_cali", 32'(CALI_EN), 32'd1);
    chk("release_err", 32'(ERR_OUT), 32'hF000);

    // Randomized operation
    for (int i = 0; i < 400; i++) begin
      EN = ($urandom_range(0, 49) != 0);
      FCW_FRAC = 16'($urandom);
      if ($urandom_range(0, 15) == 0) ERR_GAIN = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) BBPD = ~BBPD;
      if ($urandom_range(0, 63) == 0) SETTLE_CNT = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 31) == 0) RUN_MAX = 6'($urandom_range(0, 6));
      tick("rand");
    end

    // Disable mid-RUN
    EN = 1'b0;
    tick("pre_run");
    EN = 1'b1; RUN_MAX = '0; SETTLE_CNT = 8'd1; FCW_FRAC = 16'h9000;
    edges_to_cali("to_run", n);
    chk("reach_run", 32'(CALI_EN), 32'd1);
    EN = 1'b0;
    frozen = m_acc[15:0];
    for (int i = 0; i < 2; i++) begin
      tick("en_off");
      chk("en_off_cali", 32'(CALI_EN), 32'd0);
      chk("en_off_carry", 32'(DIV_CARRY), 32'd0);
      chk("en_off_phase", 32'(PHASE_OUT), 32'(frozen));
    end

    // Asynchronous reset between edges mid-RUN
    EN = 1'b1; SETTLE_CNT = 8'd2; FCW_FRAC = 16'h0777;
    edges_to_cali("to_run2", n);
    chk("reach_run2", 32'(CALI_EN), 32'd1);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_phase", 32'(PHASE_OUT), 32'd0);
    chk("arst_carry", 32'(DIV_CARRY), 32'd0);
    chk("arst_err", 32'(ERR_OUT), 32'd0);
    chk("arst_cali", 32'(CALI_EN), 32'd0);
    chk("arst_hold", 32'(HOLD), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    check_all("rst_held");
    @(negedge CLK);
    RST = 1'b0;
    SETTLE_CNT = 8'd4;
    edges_to_cali("resettle", n);
    chk("resettle_edges", 32'(n), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
